// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift classification used by both the datapath and the frame counter.
// Optional feature macro: SHIFT_REG_ASR_EN (mode 111 becomes arithmetic shift right).
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_ASR  = 3'b111;

    // True for every mode that moves bits and therefore advances the frame count
    function automatic logic is_shift(input logic [2:0] mode);
        logic res;
        res = 1'b0;
        case (mode)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: res = 1'b1;
`ifdef SHIFT_REG_ASR_EN
            MODE_ASR:                               res = 1'b1;
`endif
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Shift counter for the universal shift register. Counts shifts modulo WIDTH
// and emits a one-cycle registered pulse when a full frame has been shifted.
module shift_frame_cnt #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc,
    input  logic          zero,
    output logic [CW-1:0] cnt,
    output logic          frame_done
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Count shifts, wrap at WIDTH, and flag the wrap for exactly one cycle
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (zero) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_LAST) begin
                cnt        <= '0;
                frame_done <= 1'b1;
            end else begin
                cnt        <= cnt + CW'(1);
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: hold, logical shifts, rotates,
// parallel load and synchronous clear, with a frame counter that pulses
// frame_done after every WIDTH shifts.
// Optional feature macro: SHIFT_REG_ASR_EN (mode 111 = arithmetic shift right;
// otherwise mode 111 holds and does not count).
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    logic cnt_inc;
    logic cnt_zero;

    // Counter controls: only enabled shifts advance, load/clear restart the frame
    always_comb begin
        cnt_inc  = en && is_shift(mode);
        cnt_zero = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));
    end

    // Register update; clr dominates, en=0 freezes the contents
    always_ff @(posedge clk) begin
        if (!clr) begin
            Q <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHL:  Q <= {Q[WIDTH-2:0], sin_r};
                MODE_SHR:  Q <= {sin_l, Q[WIDTH-1:1]};
                MODE_ROL:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_ROR:  Q <= {Q[0], Q[WIDTH-1:1]};
                MODE_LOAD: Q <= pdin;
                MODE_CLR:  Q <= '0;
`ifdef SHIFT_REG_ASR_EN
                MODE_ASR:  Q <= {Q[WIDTH-1], Q[WIDTH-1:1]};
`endif
                default:   Q <= Q;
            endcase
        end
    end

    // Serial outputs taken straight from the register ends
    always_comb begin
        sout_l = Q[WIDTH-1];
        sout_r = Q[0];
    end

    shift_frame_cnt #(
        .WIDTH(WIDTH)
    ) u_frame_cnt (
        .clk       (clk),
        .clr       (clr),
        .inc       (cnt_inc),
        .zero      (cnt_zero),
        .cnt       (cnt),
        .frame_done(frame_done)
    );

endmodule
